limn2600_mem_arbiter: RTL

Two-port arbiter that shares the single-ported Limn2600 SRAM/ROM/NVRAM bus between the CPU instruction-fetch port (read-only) and the data port (read/write). It keeps at most one access outstanding, grants by round-robin on conflict, and drives the SRAM's cs/we/addr/data_in. It returns read data with a one-cycle ack pulse, and enforces alignment and a rdy timeout so a requester never hangs.

---
 rtl/limn2600_mem_pkg.sv | 20 ++
 rtl/limn2600_rr_arb2.sv | 20 ++
 rtl/limn2600_mem_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/limn2600_mem_pkg.sv
// Shared types and constants for the Limn2600 memory arbiter.
// Holds the FSM state and port-id encodings plus the word-alignment mask.
package limn2600_mem_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_id_e;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/limn2600_rr_arb2.sv
// Two-way round-robin pick: one-hot grant from a request pair and the last winner.
// Bit 0 is the fetch port, bit 1 the data port; last_grant=1 means data won last.
module limn2600_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt_c
);

  always_comb begin
    gnt_c = 2'b00;
    case (req)
      2'b01:   gnt_c = 2'b01;
      2'b10:   gnt_c = 2'b10;
      // On conflict the port that did not win last time goes first
      2'b11:   gnt_c = last_grant ? 2'b01 : 2'b10;
      default: gnt_c = 2'b00;
    endcase
  end

endmodule

// File: rtl/limn2600_mem_arbiter.sv
// Arbitrates the single-ported Limn2600 memory bus between instruction fetch and data.
// One access outstanding at a time; aligned accesses take IDLE -> ISSUE -> WAIT.
module limn2600_mem_arbiter
  import limn2600_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned TMO_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_ack,
  output logic                  if_err,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [31:0]           d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic                  d_err,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rdy,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  arb_state_e            state_q, state_d;
  port_id_e              last_grant_q, last_grant_d;
  port_id_e              gnt_port_q, gnt_port_d;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                  if_ack_q, if_ack_d;
  logic                  if_err_q, if_err_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic                  d_ack_q, d_ack_d;
  logic                  d_err_q, d_err_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  mem_cs_q, mem_cs_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic [1:0]            elig_c;
  logic [1:0]            gnt_c;
  port_id_e              sel_port_c;
  logic [ADDR_W-1:0]     sel_addr_c;
  logic                  sel_we_c;
  logic [DATA_WIDTH-1:0] sel_wdata_c;
  logic                  done_c;
  port_id_e              done_port_c;
  logic                  done_err_c;
  logic [DATA_WIDTH-1:0] done_rdata_c;
  logic [TMO_W-1:0]      tmo_next_c;

  // A port still holding req during its own ack cycle is not eligible
  assign elig_c[0] = if_req & ~if_ack_q;
  assign elig_c[1] = d_req  & ~d_ack_q;

  limn2600_rr_arb2 u_rr (
    .req        (elig_c),
    .last_grant (last_grant_q == PORT_D),
    .gnt_c      (gnt_c)
  );

  assign sel_port_c  = gnt_c[1] ? PORT_D : PORT_IF;
  assign sel_addr_c  = gnt_c[1] ? d_addr : if_addr;
  assign sel_we_c    = gnt_c[1] & d_we;
  assign sel_wdata_c = gnt_c[1] ? d_wdata : '0;
  assign tmo_next_c  = tmo_cnt_q + TMO_W'(1);

  // Next-state and completion logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_port_d   = gnt_port_q;
    tmo_cnt_d    = tmo_cnt_q;
    mem_cs_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    done_c       = 1'b0;
    done_port_c  = gnt_port_q;
    done_err_c   = 1'b0;
    done_rdata_c = '0;

    case (state_q)
      IDLE: begin
        if (|gnt_c) begin
          last_grant_d = sel_port_c;
          if ((sel_addr_c[1:0] & ALIGN_MASK) != 2'b00) begin
            done_c      = 1'b1;
            done_port_c = sel_port_c;
            done_err_c  = 1'b1;
          end else begin
            gnt_port_d  = sel_port_c;
            mem_cs_d    = 1'b1;
            mem_we_d    = sel_we_c;
            mem_addr_d  = sel_addr_c;
            mem_wdata_d = sel_wdata_c;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (mem_rdy) begin
          done_c       = 1'b1;
          done_rdata_c = mem_we_q ? '0 : mem_rdata;
          state_d      = IDLE;
        end else begin
          tmo_cnt_d = tmo_next_c;
          if (tmo_next_c == TMO_W'(TIMEOUT_CYCLES)) begin
            done_c     = 1'b1;
            done_err_c = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if_ack_d   = done_c & (done_port_c == PORT_IF);
    if_err_d   = done_c & (done_port_c == PORT_IF) & done_err_c;
    if_rdata_d = (done_c && done_port_c == PORT_IF) ? done_rdata_c : if_rdata_q;
    d_ack_d    = done_c & (done_port_c == PORT_D);
    d_err_d    = done_c & (done_port_c == PORT_D) & done_err_c;
    d_rdata_d  = (done_c && done_port_c == PORT_D) ? done_rdata_c : d_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_D;
      gnt_port_q   <= PORT_IF;
      tmo_cnt_q    <= '0;
      if_ack_q     <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= '0;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_port_q   <= gnt_port_d;
      tmo_cnt_q    <= tmo_cnt_d;
      if_ack_q     <= if_ack_d;
      if_err_q     <= if_err_d;
      if_rdata_q   <= if_rdata_d;
      d_ack_q      <= d_ack_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
      mem_cs_q     <= mem_cs_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
